// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - Viterbi decoder frame sequencer; optional watchdog via VITERBI_CTRL_WDOG_EN
module viterbi_frame_ctrl #(
  parameter int FRAME   = 512,
  parameter int LEN_W   = 15,
  parameter int TIMEOUT = 4096
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic             cin_valid,
  input  logic             cin_data,
  output logic             cin_ready,
  output logic             dec_start,
  output logic [LEN_W-1:0] dec_length,
  output logic             dec_x,
  input  logic             dec_out,
  input  logic             dec_valid,
  output logic             dout_valid,
  output logic             dout_data,
  output logic             dout_last,
  output logic             busy,
  output logic             err_len,
  output logic             err_timeout
);

  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int CW    = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_ocnt;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_dec_x;
  logic             r_err_len;
  logic             r_buf [DEPTH];

  logic [CW-1:0]    w_len2;
  logic [CW-1:0]    w_wptr_e;
  logic [CW-1:0]    w_rptr_e;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_cin_ready;
  logic             w_cin_fire;
  logic             w_load_done;
  logic             w_x_more;
  logic             w_dv;
  logic             w_last;
  logic             w_timeout;

  // Coded-bit count is twice the data length, kept one bit wider than len
  assign w_len2      = {r_len, 1'b0};
  assign w_wptr_e    = CW'(r_wptr);
  assign w_rptr_e    = CW'(r_rptr);
  assign w_len_ok    = (req_len != '0) && (req_len <= LEN_W'(FRAME));
  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_cin_ready = (r_state == S_LOAD) && (w_wptr_e < w_len2);
  assign w_cin_fire  = cin_valid && w_cin_ready;
  assign w_load_done = w_cin_fire && ((w_wptr_e + CW'(1)) == w_len2);
  assign w_x_more    = w_rptr_e < w_len2;
  // The first valid seen in RUN is already a frame bit, so RUN passes it through too
  assign w_dv        = dec_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_last      = w_dv && ((r_ocnt + LEN_W'(1)) == r_len);

`ifdef VITERBI_CTRL_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wdog;

  // Count cycles spent waiting for the decoder after the final coded bit went out
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wdog <= '0;
    end else if (w_load_done) begin
      r_wdog <= '0;
    end else if ((r_state == S_RUN) && !w_x_more && (r_wdog != WW'(TIMEOUT))) begin
      r_wdog <= r_wdog + WW'(1);
    end
  end

  assign w_timeout = (r_state == S_RUN) && !w_x_more && !dec_valid && (r_wdog == WW'(TIMEOUT));
`else
  // Without the watchdog RUN waits for dec_valid indefinitely; TIMEOUT has no effect
  assign w_timeout = 1'b0 & (TIMEOUT != 0);
`endif

  // State register; reset aborts any frame and drops dec_start immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    cin_ready   = 1'b0;
    dec_start   = 1'b0;
    dec_length  = '0;
    busy        = 1'b0;
    dout_valid  = 1'b0;
    dout_data   = 1'b0;
    dout_last   = 1'b0;
    dec_x       = r_dec_x;
    err_len     = r_err_len;
    err_timeout = w_timeout;
    case (r_state)
      S_IDLE: begin
        req_ready = !Reset;
        if (w_accept && w_len_ok) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        dec_length = r_len;
        cin_ready  = w_cin_ready;
        if (w_load_done) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        dec_length = r_len;
        dec_start  = 1'b1;
        dout_valid = w_dv;
        dout_data  = w_dv && dec_out;
        dout_last  = w_last;
        if (dec_valid) begin
          w_next = w_last ? S_GAP : S_DRAIN;
        end else if (w_timeout) begin
          w_next = S_GAP;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        dec_length = r_len;
        dec_start  = 1'b1;
        dout_valid = w_dv;
        dout_data  = w_dv && dec_out;
        dout_last  = w_last;
        if (w_last) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        busy       = 1'b1;
        dec_length = r_len;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Length latch, pointers, output count and the registered coded stream
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_len     <= '0;
      r_ocnt    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_dec_x   <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dec_x <= 1'b0;
          if (w_accept) begin
            r_len     <= req_len;
            r_ocnt    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_err_len <= !w_len_ok;
          end
        end
        S_LOAD: begin
          r_dec_x <= 1'b0;
          if (w_cin_fire) begin
            r_wptr <= r_wptr + PW'(1);
          end
          // buffer[0] must be on dec_x in the very first dec_start cycle
          if (w_load_done) begin
            r_dec_x <= r_buf[0];
            r_rptr  <= PW'(1);
          end
        end
        S_RUN, S_DRAIN: begin
          r_dec_x <= w_x_more ? r_buf[r_rptr[AW-1:0]] : 1'b0;
          if (w_x_more) begin
            r_rptr <= r_rptr + PW'(1);
          end
          if (w_dv) begin
            r_ocnt <= r_ocnt + LEN_W'(1);
          end
        end
        default: begin
          r_dec_x <= 1'b0;
        end
      endcase
    end
  end

  // Coded-bit storage; no reset needed since only written slots are ever read
  always_ff @(posedge Clk) begin
    if (w_cin_fire) begin
      r_buf[r_wptr[AW-1:0]] <= cin_data;
    end
  end

endmodule
